// File: rtl/address_fsm_if.sv
// Handshake bundle between a 16-bit word producer, the nibble serializer and a 4-bit receiver.
// The master modport belongs to whoever drives words in and takes nibbles out.
interface address_fsm_if;
  logic        data_i_valid_i;
  logic        rec_ready_i;
  logic [15:0] data_i;
  logic        fsm_ready_o;
  logic        data_o_valid_o;
  logic [3:0]  data_o;

  modport master (
    output data_i_valid_i,
    output rec_ready_i,
    output data_i,
    input  fsm_ready_o,
    input  data_o_valid_o,
    input  data_o
  );

  modport slave (
    input  data_i_valid_i,
    input  rec_ready_i,
    input  data_i,
    output fsm_ready_o,
    output data_o_valid_o,
    output data_o
  );
endinterface

// File: rtl/address_fsm.sv
// Serializes 16-bit words into four 4-bit nibbles, MSB nibble first, over valid/ready handshakes.
// A new word can be taken on the same edge as the last nibble leaves, so streaming has no bubbles.
module address_fsm (
  input  logic          clk_i,
  input  logic          arst_ni,
  address_fsm_if.slave  bus
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      word_q  <= 16'h0000;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  // data_o comes only from word_q, never from data_i, so there is no input-to-output path.
  always_comb begin
    state_d            = state_q;
    word_d             = word_q;
    cnt_d              = cnt_q;
    bus.fsm_ready_o    = 1'b0;
    bus.data_o_valid_o = 1'b0;
    bus.data_o         = 4'h0;

    case (state_q)
      IDLE: begin
        bus.fsm_ready_o = 1'b1;
        if (bus.data_i_valid_i) begin
          word_d  = bus.data_i;
          cnt_d   = 2'd0;
          state_d = SEND;
        end
      end

      SEND: begin
        bus.data_o_valid_o = 1'b1;
        case (cnt_q)
          2'd0:    bus.data_o = word_q[15:12];
          2'd1:    bus.data_o = word_q[11:8];
          2'd2:    bus.data_o = word_q[7:4];
          default: bus.data_o = word_q[3:0];
        endcase
        bus.fsm_ready_o = (cnt_q == 2'd3) && bus.rec_ready_i;

        // Any edge with rec_ready_i low leaves everything untouched (backpressure).
        if (bus.rec_ready_i) begin
          if (cnt_q != 2'd3) begin
            cnt_d = cnt_q + 2'd1;
          end else if (bus.data_i_valid_i) begin
            word_d = bus.data_i;
            cnt_d  = 2'd0;
          end else begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_address_fsm.sv
// Self-checking bench for address_fsm: directed scenarios plus random traffic, all compared
// against a queue of pending nibbles that stands in for the serializer's behaviour.
module tb_address_fsm;

  logic clk_i;
  logic arst_ni;

  address_fsm_if bus_if ();

  address_fsm dut (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .bus     (bus_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total_checks = 0;
  int bad_checks   = 0;

  // Nibbles still owed to the receiver, oldest first; empty means the block is idle.
  logic [3:0] pending_q[$];

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the outputs against the
  // pending-nibble queue, then apply the handshake rules to the queue at the rising edge.
  task automatic applyStimulus(input logic valid, input logic [15:0] word, input logic rr);
    logic       exp_valid;
    logic [3:0] exp_data;
    logic       exp_ready;
    @(negedge clk_i);
    bus_if.data_i_valid_i = valid;
    bus_if.data_i         = word;
    bus_if.rec_ready_i    = rr;
    #1;
    exp_valid = (pending_q.size() != 0);
    exp_data  = exp_valid ? pending_q[0] : 4'h0;
    exp_ready = (pending_q.size() == 0) || ((pending_q.size() == 1) && rr);
    checkOutput("valid", {15'd0, bus_if.data_o_valid_o}, {15'd0, exp_valid});
    checkOutput("data",  {12'd0, bus_if.data_o},         {12'd0, exp_data});
    checkOutput("ready", {15'd0, bus_if.fsm_ready_o},    {15'd0, exp_ready});
    @(posedge clk_i);
    if (exp_valid && rr) void'(pending_q.pop_front());
    if (valid && exp_ready) begin
      pending_q.push_back(word[15:12]);
      pending_q.push_back(word[11:8]);
      pending_q.push_back(word[7:4]);
      pending_q.push_back(word[3:0]);
    end
  endtask

  initial begin
    bus_if.data_i_valid_i = 1'b0;
    bus_if.data_i         = 16'h0000;
    bus_if.rec_ready_i    = 1'b0;
    arst_ni               = 1'b0;

    // Reset state while held in reset.
    #3;
    checkOutput("rst_valid", {15'd0, bus_if.data_o_valid_o}, 16'd0);
    checkOutput("rst_data",  {12'd0, bus_if.data_o},         16'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    arst_ni = 1'b1;
    #1;
    checkOutput("rel_ready", {15'd0, bus_if.fsm_ready_o}, 16'd1);

    // Single word, receiver always ready.
    applyStimulus(1'b1, 16'hABCD, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 16'h0000, 1'b1);

    // Streaming with valid held high: CAFE is offered while busy, DEAD at the last-nibble edge.
    applyStimulus(1'b1, 16'hABCD, 1'b1);
    applyStimulus(1'b1, 16'hCAFE, 1'b1);
    applyStimulus(1'b1, 16'hCAFE, 1'b1);
    applyStimulus(1'b1, 16'hDEAD, 1'b1);
    applyStimulus(1'b1, 16'hDEAD, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 16'h0000, 1'b1);

    // Backpressure at nibble 2 of 1234 for three cycles.
    applyStimulus(1'b1, 16'h1234, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'hFFFF, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b1);

    // Stall on the last nibble with a new word waiting; it must wait for rec_ready_i.
    applyStimulus(1'b1, 16'h4321, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h9E3C, 1'b0);
    applyStimulus(1'b1, 16'h9E3C, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 16'h0000, 1'b1);

    // Asynchronous reset while nibble 1 of 5A5A is on the output.
    applyStimulus(1'b1, 16'h5A5A, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    @(negedge clk_i);
    bus_if.rec_ready_i = 1'b0;
    #2;
    arst_ni = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {15'd0, bus_if.data_o_valid_o}, 16'd0);
    checkOutput("mid_rst_data",  {12'd0, bus_if.data_o},         16'd0);
    pending_q.delete();
    @(posedge clk_i);
    #2;
    arst_ni = 1'b1;
    applyStimulus(1'b1, 16'h9876, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 16'h0000, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/address_fsm.md
Name: address_fsm

Overview:
- Width-converting serializer: accepts a 16-bit word over a valid/ready handshake and emits it as four 4-bit nibbles over a second valid/ready handshake, most-significant nibble first.
- Sits between a 16-bit address/data producer and a 4-bit-wide downstream receiver.
- Supports back-to-back words with no idle cycle between them.

Parameters:
- None. Widths are fixed: 16-bit input, 4-bit output, 4 nibbles per word.

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- arst_ni  input  1  reset, asynchronous, active-low
- data_i_valid_i  input  1  upstream word valid
- rec_ready_i  input  1  downstream receiver ready to take a nibble
- data_i  input  16  upstream word
- fsm_ready_o  output  1  block can accept a word this cycle
- data_o_valid_o  output  1  data_o holds a valid nibble
- data_o  output  4  current nibble

Behaviour:
- Interface: single clock clk_i; reset arst_ni is asynchronous and active-low.
- Registers:
  - state: IDLE or SEND.
  - word_q: 16-bit captured word.
  - cnt_q: 2-bit nibble index.
- Reset (arst_ni=0, asynchronous): state=IDLE, word_q=0, cnt_q=0. Outputs are then data_o_valid_o=0, data_o=0, fsm_ready_o=1 (once reset is released, IDLE drives ready high).
- Reset mid-operation discards any partially sent word. After release the block is in IDLE with no residual output.
- Input handshake: a word is accepted on a rising edge where data_i_valid_i=1 and fsm_ready_o=1. data_i is sampled at that edge.
- Output handshake: a nibble transfers on a rising edge where data_o_valid_o=1 and rec_ready_i=1.
- fsm_ready_o (combinational) = (state==IDLE) OR (state==SEND AND cnt_q==3 AND rec_ready_i==1).
- data_o_valid_o = (state==SEND).
- data_o = word_q[15-4*cnt_q -: 4] in SEND; 4'h0 in IDLE.
  - Order: cnt 0 -> [15:12], cnt 1 -> [11:8], cnt 2 -> [7:4], cnt 3 -> [3:0].
- IDLE transitions:
  - On acceptance: word_q<=data_i, cnt_q<=0, state<=SEND.
  - Otherwise stay in IDLE.
- SEND, no transfer (rec_ready_i=0): hold word_q, cnt_q and data_o stable (backpressure).
- SEND, transfer with cnt_q<3: cnt_q<=cnt_q+1.
- SEND, transfer with cnt_q==3:
  - If data_i_valid_i=1: accept the new word (word_q<=data_i, cnt_q<=0, stay in SEND).
  - Otherwise: state<=IDLE, cnt_q<=0.
- Latency: first nibble is valid the cycle after acceptance.
- Throughput: 4 cycles per word when rec_ready_i is held high.
- data_i changes while in SEND (other than at the last-nibble transfer edge) are ignored. data_i_valid_i may stay high continuously.
- Priority: reset overrides everything.
- No combinational path from data_i to data_o.

Test Plan:
- Reset: arst_ni=0 -> data_o_valid_o=0, data_o=0. After release, fsm_ready_o=1 while data_i_valid_i=0.
- Single word: rec_ready_i=1, word 16'hABCD valid for one cycle -> data_o = A, B, C, D on 4 consecutive cycles with valid=1, then IDLE (valid=0, ready=1).
- Streaming, valid held high:
  - Stimulus: data_i = ABCD, then CAFE and DEAD while the block is busy.
  - Response: nibbles A, B, C, D are emitted first.
  - The word present at the last-nibble edge (DEAD) is accepted next, giving D, E, A, D with no bubble.
  - CAFE is never emitted.
- Backpressure: during word 16'h1234, drop rec_ready_i for 3 cycles at nibble 2 -> data_o stays at 4'h2 with valid=1, resumes with 3, 4. fsm_ready_o=0 throughout.
- Last-nibble stall: rec_ready_i=0 with cnt_q=3 -> fsm_ready_o=0 and no new word is accepted until rec_ready_i=1.
- Reset mid-word: assert arst_ni during nibble 1 of 16'h5A5A -> outputs clear immediately (asynchronously). After release, the next word starts from its MSB nibble.
